// File: rtl/lcd_timing_ctrl_pkg.sv
// Shared video-subsystem types and LCD scanline timing constants.
package video_types;

  localparam int LCD_LINES     = 144;
  localparam int DOTS_PER_LINE = 456;
  localparam int OAM_DOTS      = 80;
  localparam int XFER_DOTS     = 172;
  localparam int TOTAL_LINES   = 154;

  typedef enum logic [1:0] {
    HBLANK     = 2'd0,
    VBLANK     = 2'd1,
    OAM_SEARCH = 2'd2,
    TRANSFER   = 2'd3
  } LcdMode;

  // Level of the combined STAT interrupt request before edge detection.
  function automatic logic stat_line(input LcdMode mode, input logic coincidence,
                                     input logic [3:0] ie);
    return ((mode == HBLANK)     && ie[0]) ||
           ((mode == VBLANK)     && ie[1]) ||
           ((mode == OAM_SEARCH) && ie[2]) ||
           (coincidence          && ie[3]);
  endfunction

endpackage

// File: rtl/lcd_timing_ctrl_stat_irq_gen.sv
// Rising-edge detector on the STAT request line; a line that stays high
// across a source change produces no second pulse.
module stat_irq_gen
  import video_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  LcdMode     mode_i,
  input  logic       coincidence_i,
  input  logic [3:0] stat_ie_i,
  output logic       stat_irq_o
);

  logic line_d;
  logic line_q;
  logic irq_q;

  // Disabling the LCD drops the line, which also clears the edge history.
  always_comb begin
    line_d = 1'b0;
    if (enable_i) begin
      line_d = stat_line(mode_i, coincidence_i, stat_ie_i);
    end else begin
      line_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      line_q <= line_d;
      irq_q  <= line_d && !line_q;
    end
  end

  assign stat_irq_o = irq_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Scanline sequencer: dot/line counters, LCD mode, render strobes, interrupts
// and CPU VRAM/OAM access windows, all registered from next-state values.
module lcd_timing_ctrl #(
  parameter int DOTS_PER_LINE = video_types::DOTS_PER_LINE,
  parameter int OAM_DOTS      = video_types::OAM_DOTS,
  parameter int XFER_DOTS     = video_types::XFER_DOTS,
  parameter int VISIBLE_LINES = video_types::LCD_LINES,
  parameter int TOTAL_LINES   = video_types::TOTAL_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       coincidence,
  output logic       drawline,
  output logic       render_complete,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       vram_cpu_ok,
  output logic       oam_cpu_ok
);

  import video_types::*;

  localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] XFER_START   = 9'(OAM_DOTS);
  localparam logic [8:0] HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LAST_LINE    = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VBLANK_LINE  = 8'(VISIBLE_LINES);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic       running_q;
  LcdMode     mode_q, mode_d;
  logic       coin_q, coin_d;
  logic       drawline_q, vblank_q, render_q, vram_ok_q, oam_ok_q;

  // Counters only advance once a previous edge has already seen the LCD on,
  // so the first enabled cycle always lands on dot 0 of line 0.
  always_comb begin
    dot_d  = 9'd0;
    ly_d   = 8'd0;
    mode_d = HBLANK;
    if (lcd_enable && running_q) begin
      if (dot_q == LAST_DOT) begin
        dot_d = 9'd0;
        ly_d  = (ly_q == LAST_LINE) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
        ly_d  = ly_q;
      end
    end else begin
      dot_d = 9'd0;
      ly_d  = 8'd0;
    end

    if (!lcd_enable) begin
      mode_d = HBLANK;
    end else if (ly_d >= VBLANK_LINE) begin
      mode_d = VBLANK;
    end else if (dot_d < XFER_START) begin
      mode_d = OAM_SEARCH;
    end else if (dot_d < HBLANK_START) begin
      mode_d = TRANSFER;
    end else begin
      mode_d = HBLANK;
    end

    coin_d = (ly_d == lyc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running_q  <= 1'b0;
      dot_q      <= 9'd0;
      ly_q       <= 8'd0;
      mode_q     <= HBLANK;
      coin_q     <= 1'b0;
      drawline_q <= 1'b0;
      vblank_q   <= 1'b0;
      render_q   <= 1'b0;
      vram_ok_q  <= 1'b1;
      oam_ok_q   <= 1'b1;
    end else begin
      running_q  <= lcd_enable;
      dot_q      <= dot_d;
      ly_q       <= ly_d;
      mode_q     <= mode_d;
      coin_q     <= coin_d;
      drawline_q <= lcd_enable && (ly_d < VBLANK_LINE) && (dot_d == XFER_START);
      vblank_q   <= lcd_enable && (ly_d == VBLANK_LINE) && (dot_d == 9'd0);
      render_q   <= (mode_d == VBLANK);
      vram_ok_q  <= (mode_d != TRANSFER);
      oam_ok_q   <= (mode_d != TRANSFER) && (mode_d != OAM_SEARCH);
    end
  end

  stat_irq_gen u_stat_irq_gen (
    .clk           (clk),
    .rst_n         (reset),
    .enable_i      (lcd_enable),
    .mode_i        (mode_d),
    .coincidence_i (coin_d),
    .stat_ie_i     (stat_ie),
    .stat_irq_o    (stat_irq)
  );

  assign ly              = ly_q;
  assign mode            = mode_q;
  assign coincidence     = coin_q;
  assign drawline        = drawline_q;
  assign vblank_irq      = vblank_q;
  assign render_complete = render_q;
  assign vram_cpu_ok     = vram_ok_q;
  assign oam_cpu_ok      = oam_ok_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Scoreboard bench: instance A runs a full frame with LYC coincidence,
// instance B covers STAT blocking, mid-line disable and asynchronous reset.
module tb_lcd_timing_ctrl;

  typedef struct packed {
    logic [7:0] ly;
    logic [1:0] mode;
    logic [2:0] s;
    logic       coin;
    logic       rc;
    logic       vok;
    logic       ook;
  } obs_t;

  typedef struct {
    int   inst;
    int   cyc;
    obs_t exp;
  } lvl_t;

  typedef struct {
    int         inst;
    int         cyc;
    logic [7:0] ly;
    logic [2:0] s;
  } ev_t;

  localparam int LINE  = 456;
  localparam int FRAME = 70224;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_a = 1'b0, done_b = 1'b0, drain_req = 1'b0, drained = 1'b0;
  event snap_ev;

  lvl_t lvl_q[$];
  ev_t  ev_q[$];

  logic       rst_a, en_a, rst_b, en_b;
  logic [7:0] lyc_a, lyc_b;
  logic [3:0] ie_a, ie_b;
  logic [7:0] ly_a, ly_b;
  logic [1:0] mode_a, mode_b;
  logic       coin_a, dl_a, rc_a, vb_a, st_a, vok_a, ook_a;
  logic       coin_b, dl_b, rc_b, vb_b, st_b, vok_b, ook_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_timing_ctrl dut_a (
    .clk(clk), .reset(rst_a), .lcd_enable(en_a), .lyc(lyc_a), .stat_ie(ie_a),
    .ly(ly_a), .mode(mode_a), .coincidence(coin_a), .drawline(dl_a),
    .render_complete(rc_a), .vblank_irq(vb_a), .stat_irq(st_a),
    .vram_cpu_ok(vok_a), .oam_cpu_ok(ook_a)
  );

  lcd_timing_ctrl dut_b (
    .clk(clk), .reset(rst_b), .lcd_enable(en_b), .lyc(lyc_b), .stat_ie(ie_b),
    .ly(ly_b), .mode(mode_b), .coincidence(coin_b), .drawline(dl_b),
    .render_complete(rc_b), .vblank_irq(vb_b), .stat_irq(st_b),
    .vram_cpu_ok(vok_b), .oam_cpu_ok(ook_b)
  );

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0) o = {ly_a, mode_a, dl_a, vb_a, st_a, coin_a, rc_a, vok_a, ook_a};
    else        o = {ly_b, mode_b, dl_b, vb_b, st_b, coin_b, rc_b, vok_b, ook_b};
    return o;
  endfunction

  task automatic exp_lvl(input int inst, input int at, input logic [7:0] ly,
                         input logic [1:0] mode, input logic [2:0] s, input logic coin,
                         input logic rc, input logic vok, input logic ook);
    lvl_t t;
    t.inst = inst;
    t.cyc  = at;
    t.exp  = {ly, mode, s, coin, rc, vok, ook};
    lvl_q.push_back(t);
  endtask

  task automatic exp_ev(input int inst, input int at, input logic [7:0] ly, input logic [2:0] s);
    ev_t t;
    t.inst = inst;
    t.cyc  = at;
    t.ly   = ly;
    t.s    = s;
    ev_q.push_back(t);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_lvl(input lvl_t t);
    obs_t o;
    o = get_obs(t.inst);
    n_vec++;
    if (o !== t.exp) begin
      n_err++;
      $display("FAIL level inst%0d cyc %0d: got ly=%0d mode=%0d strb=%b coin=%b rc=%b vok=%b ook=%b, required ly=%0d mode=%0d strb=%b coin=%b rc=%b vok=%b ook=%b",
               t.inst, t.cyc, o.ly, o.mode, o.s, o.coin, o.rc, o.vok, o.ook,
               t.exp.ly, t.exp.mode, t.exp.s, t.exp.coin, t.exp.rc, t.exp.vok, t.exp.ook);
    end
  endtask

  // Monitor: level snapshots by cycle, strobes popped in order per instance.
  initial begin
    forever begin
      @(negedge clk or snap_ev);
      if (clk == 1'b1) begin
        for (int k = lvl_q.size() - 1; k >= 0; k--) begin
          if (lvl_q[k].cyc == -1) begin
            check_lvl(lvl_q[k]);
            lvl_q.delete(k);
          end
        end
      end else begin
        for (int k = lvl_q.size() - 1; k >= 0; k--) begin
          if (lvl_q[k].cyc == cyc) begin
            check_lvl(lvl_q[k]);
            lvl_q.delete(k);
          end
        end
        for (int i = 0; i < 2; i++) begin
          obs_t o;
          int   idx;
          o   = get_obs(i);
          idx = -1;
          if (o.s != 3'b000) begin
            for (int k = 0; k < ev_q.size(); k++) begin
              if (idx < 0 && ev_q[k].inst == i) idx = k;
            end
            n_vec++;
            if (idx < 0) begin
              n_err++;
              $display("FAIL strobe inst%0d cyc %0d: got strb=%b ly=%0d, required no strobe",
                       i, cyc, o.s, o.ly);
            end else begin
              if (ev_q[idx].cyc != cyc || ev_q[idx].s != o.s || ev_q[idx].ly != o.ly) begin
                n_err++;
                $display("FAIL strobe inst%0d: got cyc %0d strb=%b ly=%0d, required cyc %0d strb=%b ly=%0d",
                         i, cyc, o.s, o.ly, ev_q[idx].cyc, ev_q[idx].s, ev_q[idx].ly);
              end
              ev_q.delete(idx);
            end
          end
        end
        if (drain_req && !drained) begin
          n_vec++;
          if (ev_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_events: got %0d strobes never seen, required 0", ev_q.size());
          end
          n_vec++;
          if (lvl_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_levels: got %0d snapshots never taken, required 0", lvl_q.size());
          end
          drained = 1'b1;
        end
      end
    end
  end

  // Instance A: reset release, one full frame, coincidence on line 10.
  initial begin
    int e;
    rst_a = 1'b0; en_a = 1'b1; lyc_a = 8'd10; ie_a = 4'b1000;
    repeat (3) @(negedge clk);
    exp_lvl(0, cyc + 1, 8'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_a = 1'b1;
    e = cyc + 1;
    for (int l = 0; l < 144; l++) begin
      if (l == 10) exp_ev(0, e + 10 * LINE, 8'd10, 3'b001);
      exp_ev(0, e + l * LINE + 80, 8'(l), 3'b100);
    end
    exp_ev(0, e + 144 * LINE, 8'd144, 3'b010);
    exp_lvl(0, e,                 8'd0,   2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(0, e + 80,            8'd0,   2'd3, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_lvl(0, e + 252,           8'd0,   2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(0, e + 455,           8'd0,   2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(0, e + LINE,          8'd1,   2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(0, e + 10 * LINE,     8'd10,  2'd2, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_lvl(0, e + 11 * LINE - 1, 8'd10,  2'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_lvl(0, e + 11 * LINE,     8'd11,  2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(0, e + 144 * LINE - 1, 8'd143, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(0, e + 144 * LINE,    8'd144, 2'd1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_lvl(0, e + FRAME - 1,     8'd153, 2'd1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_lvl(0, e + FRAME,         8'd0,   2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cyc(e + FRAME + 1);
    rst_a  = 1'b0;
    done_a = 1'b1;
  end

  // Instance B: STAT blocking, disable at ly 50 dot 100, async reset in ly 70.
  initial begin
    int e, d, r;
    rst_b = 1'b0; en_b = 1'b1; lyc_b = 8'd200; ie_b = 4'b0001;
    repeat (3) @(negedge clk);
    exp_lvl(1, cyc + 1, 8'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_b = 1'b1;
    e = cyc + 1;
    for (int l = 0; l < 50; l++) begin
      exp_ev(1, e + l * LINE + 80, 8'(l), 3'b100);
      exp_ev(1, e + l * LINE + 252, 8'(l), 3'b001);
    end
    exp_ev(1, e + 50 * LINE + 80, 8'd50, 3'b100);
    exp_lvl(1, e,                    8'd0,  2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(1, e + 252,              8'd0,  2'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(1, e + LINE,             8'd1,  2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(1, e + LINE + 252,       8'd1,  2'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(1, e + 50 * LINE + 100,  8'd50, 2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    d = e + 50 * LINE + 101;
    exp_lvl(1, d,                    8'd0,  2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_lvl(1, d + 2,                8'd0,  2'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_cyc(e + 100);
    ie_b = 4'b0101;
    wait_cyc(d - 1);
    en_b = 1'b0;
    wait_cyc(d + 1);
    lyc_b = 8'd0;
    ie_b  = 4'b0001;
    wait_cyc(d + 4);
    en_b = 1'b1;
    r = d + 5;
    for (int l = 0; l < 70; l++) begin
      exp_ev(1, r + l * LINE + 80, 8'(l), 3'b100);
      exp_ev(1, r + l * LINE + 252, 8'(l), 3'b001);
    end
    exp_ev(1, r + 70 * LINE + 80, 8'd70, 3'b100);
    exp_lvl(1, r,                   8'd0,  2'd2, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_lvl(1, r + LINE,            8'd1,  2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_lvl(1, r + 70 * LINE + 100, 8'd70, 2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(r + 70 * LINE + 100);
    exp_lvl(1, -1, 8'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    -> snap_ev;
    @(negedge clk);
    done_b = 1'b1;
  end

  initial begin
    wait (done_a && done_b);
    repeat (3) @(negedge clk);
    drain_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget 80000 expired at cyc %0d, required completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
